// File: rtl/sprite_palette_bank.sv
// Banked sprite palette with per-channel lookup and priority compositing.
// Two-stage pipeline: palette read, then lowest-channel-wins composite over background.
module sprite_palette_bank #(
  parameter int NUM_CH       = 4,
  parameter int IDX_W        = 4,
  parameter int BANK_W       = 2,
  parameter int TRANS_IDX    = 0,
  parameter int FLASH_FRAMES = 16,
  localparam int HCH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     Clk,
  input  logic                     Reset_n,
  input  logic                     wr_en,
  input  logic [BANK_W-1:0]        wr_bank,
  input  logic [IDX_W-1:0]         wr_index,
  input  logic [11:0]              wr_rgb,
  input  logic                     frame_start,
  input  logic                     flash_en,
  input  logic [11:0]              bg_rgb,
  input  logic                     pix_valid_in,
  input  logic [NUM_CH-1:0]        ch_active,
  input  logic [NUM_CH*BANK_W-1:0] ch_bank,
  input  logic [NUM_CH*IDX_W-1:0]  ch_index,
  input  logic [NUM_CH-1:0]        ch_flash,
  output logic                     pix_valid_out,
  output logic [3:0]               red,
  output logic [3:0]               green,
  output logic [3:0]               blue,
  output logic                     hit,
  output logic [HCH_W-1:0]         hit_ch,
  output logic                     flash_phase
);

  localparam int NUM_ENT = 1 << (BANK_W + IDX_W);
  localparam int CNT_W   = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
  localparam logic [BANK_W-1:0] BANK_ONE  = BANK_W'(1);
  localparam logic [IDX_W-1:0]  TRANS     = IDX_W'(TRANS_IDX);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(FLASH_FRAMES - 1);

  logic [11:0]       pal [NUM_ENT];
  logic [CNT_W-1:0]  frame_cnt;
  logic              phase;

  // Palette storage; reads below see the pre-write value in a same-cycle write.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < NUM_ENT; i++) pal[i] <= 12'h000;
    end else if (wr_en) begin
      pal[{wr_bank, wr_index}] <= wr_rgb;
    end
  end

  // Frame counter only runs while flashing is enabled; disabling resets the phase.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      frame_cnt <= '0;
      phase     <= 1'b0;
    end else if (!flash_en) begin
      frame_cnt <= '0;
      phase     <= 1'b0;
    end else if (frame_start) begin
      if (frame_cnt == CNT_LAST) begin
        frame_cnt <= '0;
        phase     <= ~phase;
      end else begin
        frame_cnt <= frame_cnt + CNT_W'(1);
      end
    end
  end

  assign flash_phase = phase;

  logic [BANK_W-1:0] eff_bank [NUM_CH];
  logic [11:0]       rd_rgb   [NUM_CH];
  logic [NUM_CH-1:0] rd_trans;

  always_comb begin
    rd_trans = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      eff_bank[c] = ch_bank[c*BANK_W +: BANK_W];
      if (flash_en && ch_flash[c] && phase) eff_bank[c] = eff_bank[c] ^ BANK_ONE;
      rd_rgb[c]   = pal[{eff_bank[c], ch_index[c*IDX_W +: IDX_W]}];
      rd_trans[c] = (ch_index[c*IDX_W +: IDX_W] == TRANS);
    end
  end

  logic              s1_valid;
  logic [11:0]       s1_rgb [NUM_CH];
  logic [NUM_CH-1:0] s1_trans;
  logic [NUM_CH-1:0] s1_active;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s1_valid  <= 1'b0;
      s1_trans  <= '0;
      s1_active <= '0;
      for (int c = 0; c < NUM_CH; c++) s1_rgb[c] <= 12'h000;
    end else begin
      s1_valid  <= pix_valid_in;
      s1_trans  <= rd_trans;
      s1_active <= ch_active;
      for (int c = 0; c < NUM_CH; c++) s1_rgb[c] <= rd_rgb[c];
    end
  end

  logic             win;
  logic [HCH_W-1:0] win_ch;
  logic [11:0]      win_rgb;

  // Scan from the top down so the lowest-numbered opaque channel is left standing.
  always_comb begin
    win     = 1'b0;
    win_ch  = '0;
    win_rgb = bg_rgb;
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      if (s1_active[c] && !s1_trans[c]) begin
        win     = 1'b1;
        win_ch  = HCH_W'(c);
        win_rgb = s1_rgb[c];
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pix_valid_out <= 1'b0;
      red           <= 4'h0;
      green         <= 4'h0;
      blue          <= 4'h0;
      hit           <= 1'b0;
      hit_ch        <= '0;
    end else begin
      pix_valid_out <= s1_valid;
      red           <= win_rgb[11:8];
      green         <= win_rgb[7:4];
      blue          <= win_rgb[3:0];
      hit           <= win;
      hit_ch        <= win_ch;
    end
  end

endmodule

// File: tb/tb_sprite_palette_bank.sv
// Directed bench for sprite_palette_bank: lookup, priority, read-during-write,
// flash banking, throughput and mid-stream reset, with hand-computed expectations.
module tb_sprite_palette_bank;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        wr_en;
  logic [1:0]  wr_bank;
  logic [3:0]  wr_index;
  logic [11:0] wr_rgb;
  logic        frame_start;
  logic        flash_en;
  logic [11:0] bg_rgb;
  logic        pix_valid_in;
  logic [3:0]  ch_active;
  logic [7:0]  ch_bank;
  logic [15:0] ch_index;
  logic [3:0]  ch_flash;
  logic        pix_valid_out;
  logic [3:0]  red, green, blue;
  logic        hit;
  logic [1:0]  hit_ch;
  logic        flash_phase;

  int pass_cnt = 0;
  int total_cnt = 0;

  sprite_palette_bank #(
    .NUM_CH(4), .IDX_W(4), .BANK_W(2), .TRANS_IDX(0), .FLASH_FRAMES(2)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .wr_en(wr_en), .wr_bank(wr_bank), .wr_index(wr_index), .wr_rgb(wr_rgb),
    .frame_start(frame_start), .flash_en(flash_en), .bg_rgb(bg_rgb),
    .pix_valid_in(pix_valid_in), .ch_active(ch_active), .ch_bank(ch_bank),
    .ch_index(ch_index), .ch_flash(ch_flash),
    .pix_valid_out(pix_valid_out), .red(red), .green(green), .blue(blue),
    .hit(hit), .hit_ch(hit_ch), .flash_phase(flash_phase)
  );

  // Clock / reset
  always #5 Clk = ~Clk;

  // Driver tasks: inputs change 1 time unit after the rising edge.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic write_pal(input logic [1:0] b, input logic [3:0] i, input logic [11:0] rgb);
    wr_en = 1'b1; wr_bank = b; wr_index = i; wr_rgb = rgb;
    step();
    wr_en = 1'b0;
  endtask

  task automatic request(input logic [3:0] act, input logic [7:0] bnk,
                         input logic [15:0] idx, input logic [3:0] fl);
    pix_valid_in = 1'b1; ch_active = act; ch_bank = bnk; ch_index = idx; ch_flash = fl;
  endtask

  // Scoreboard check
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  logic [11:0] tp_rgb [4];
  logic        tp_v   [4];

  initial begin
    Reset_n = 1'b0; wr_en = 1'b0; wr_bank = '0; wr_index = '0; wr_rgb = '0;
    frame_start = 1'b0; flash_en = 1'b0; bg_rgb = 12'h123; pix_valid_in = 1'b0;
    ch_active = '0; ch_bank = '0; ch_index = '0; ch_flash = '0;
    tp_rgb[0] = 12'hA01; tp_rgb[1] = 12'hB02; tp_rgb[2] = 12'hC03; tp_rgb[3] = 12'hD04;
    tp_v[0] = 1'b1; tp_v[1] = 1'b0; tp_v[2] = 1'b1; tp_v[3] = 1'b1;

    // Reset state
    step(); step();
    chk("rst_valid", 16'(pix_valid_out), 16'h0);
    chk("rst_rgb", {4'h0, red, green, blue}, 16'h000);
    chk("rst_hit", {13'h0, hit, hit_ch}, 16'h0);
    chk("rst_phase", 16'(flash_phase), 16'h0);
    Reset_n = 1'b1;
    step();

    // Write then lookup
    write_pal(2'd1, 4'd5, 12'hEA0);
    request(4'b0001, 8'h01, 16'h0005, 4'b0000);
    step();
    chk("lat_not_early", 16'(pix_valid_out), 16'h0);
    pix_valid_in = 1'b0;
    step();
    chk("wl_valid", 16'(pix_valid_out), 16'h1);
    chk("wl_rgb", {4'h0, red, green, blue}, 16'h0EA0);
    chk("wl_hit", {13'h0, hit, hit_ch}, 16'h4);

    // Priority and transparency
    write_pal(2'd0, 4'd3, 12'h560);
    write_pal(2'd0, 4'd4, 12'hFA0);
    request(4'b0111, 8'h00, 16'h0430, 4'b0000);
    step();
    request(4'b1111, 8'h00, 16'h0000, 4'b0000);
    step();
    chk("prio_rgb", {4'h0, red, green, blue}, 16'h0560);
    chk("prio_hit", {13'h0, hit, hit_ch}, 16'h5);
    request(4'b1000, 8'h00, 16'h4000, 4'b0000);
    step();
    chk("trans_rgb", {4'h0, red, green, blue}, 16'h0123);
    chk("trans_hit", {13'h0, hit, hit_ch}, 16'h0);
    request(4'b0000, 8'h00, 16'h3333, 4'b0000);
    step();
    chk("ch3_rgb", {4'h0, red, green, blue}, 16'h0FA0);
    chk("ch3_hit", {13'h0, hit, hit_ch}, 16'h7);
    pix_valid_in = 1'b0;
    step();
    chk("inactive_rgb", {4'h0, red, green, blue}, 16'h0123);
    chk("inactive_hit", 16'(hit), 16'h0);

    // Read during write
    write_pal(2'd0, 4'd2, 12'h777);
    request(4'b0001, 8'h00, 16'h0002, 4'b0000);
    wr_en = 1'b1; wr_bank = 2'd0; wr_index = 4'd2; wr_rgb = 12'hD07;
    step();
    wr_en = 1'b0;
    step();
    chk("rdw_old", {4'h0, red, green, blue}, 16'h0777);
    pix_valid_in = 1'b0;
    step();
    chk("rdw_new", {4'h0, red, green, blue}, 16'h0D07);

    // Throughput with valid pattern 1,0,1,1
    for (int k = 0; k < 4; k++) write_pal(2'd2, 4'(k + 1), tp_rgb[k]);
    for (int k = 0; k < 6; k++) begin
      if (k < 4) begin
        request(4'b0001, 8'h02, 16'(k + 1), 4'b0000);
        pix_valid_in = tp_v[k];
      end else begin
        pix_valid_in = 1'b0;
      end
      step();
      if (k >= 1 && k <= 4) begin
        chk("tp_valid", 16'(pix_valid_out), 16'(tp_v[k-1]));
        chk("tp_rgb", {4'h0, red, green, blue}, {4'h0, tp_rgb[k-1]});
      end
    end

    // Flash banking
    write_pal(2'd0, 4'd6, 12'h00F);
    write_pal(2'd1, 4'd6, 12'h0F0);
    flash_en = 1'b1; frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    chk("flash_one_frame", 16'(flash_phase), 16'h0);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    chk("flash_toggle", 16'(flash_phase), 16'h1);
    request(4'b0001, 8'h00, 16'h0006, 4'b0001);
    step();
    request(4'b0001, 8'h00, 16'h0006, 4'b0000);
    step();
    chk("flash_swap_rgb", {4'h0, red, green, blue}, 16'h00F0);
    pix_valid_in = 1'b0;
    step();
    chk("flash_noflash_ch", {4'h0, red, green, blue}, 16'h000F);
    flash_en = 1'b0;
    step();
    chk("flash_drop", 16'(flash_phase), 16'h0);
    request(4'b0001, 8'h00, 16'h0006, 4'b0001);
    step();
    pix_valid_in = 1'b0;
    step();
    chk("flash_off_rgb", {4'h0, red, green, blue}, 16'h000F);

    // Mid-stream reset
    request(4'b0001, 8'h01, 16'h0005, 4'b0000);
    step();
    step();
    chk("pre_rst_valid", 16'(pix_valid_out), 16'h1);
    pix_valid_in = 1'b0;
    Reset_n = 1'b0;
    #2;
    chk("mid_rst_valid", 16'(pix_valid_out), 16'h0);
    chk("mid_rst_rgb", {4'h0, red, green, blue}, 16'h000);
    chk("mid_rst_hit", {13'h0, hit, hit_ch}, 16'h0);
    step();
    Reset_n = 1'b1;
    step();
    chk("post_rst_stale1", 16'(pix_valid_out), 16'h0);
    step();
    chk("post_rst_stale2", 16'(pix_valid_out), 16'h0);
    request(4'b0001, 8'h01, 16'h0005, 4'b0000);
    step();
    pix_valid_in = 1'b0;
    chk("post_rst_lat", 16'(pix_valid_out), 16'h0);
    step();
    chk("post_rst_valid", 16'(pix_valid_out), 16'h1);
    chk("post_rst_pal", {4'h0, red, green, blue}, 16'h000);
    chk("post_rst_hit", {13'h0, hit, hit_ch}, 16'h4);

    // Final report
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/sprite_palette_bank.md
SPRITE_PALETTE_BANK -- requirements
Module: sprite_palette_bank

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4, meaning the number of sprite channels composited per pixel.
REQ-002 The block SHALL have parameter IDX_W, default 4, meaning the colour-index width; each bank holds 2^IDX_W entries.
REQ-003 The block SHALL have parameter BANK_W, default 2, meaning the bank-select width; 2^BANK_W banks are held.
REQ-004 The block SHALL have parameter TRANS_IDX, default 0, meaning the colour index treated as transparent.
REQ-005 The block SHALL have parameter FLASH_FRAMES, default 16, meaning the number of frames per flash phase (at least 1).
REQ-006 The block SHALL have one clock and an asynchronous, active-low reset, with ports:
- Clk  in  1  rising-edge clock
- Reset_n  in  1  asynchronous active-low reset
- wr_en  in  1  palette write strobe
- wr_bank  in  BANK_W  write bank
- wr_index  in  IDX_W  write entry
- wr_rgb  in  12  {R,G,B} nibbles to write
- frame_start  in  1  one-cycle pulse per video frame
- flash_en  in  1  global flash enable
- bg_rgb  in  12  background colour
- pix_valid_in  in  1  pixel request valid
- ch_active  in  NUM_CH  per-channel sprite coverage
- ch_bank  in  NUM_CH*BANK_W  per-channel bank, channel c at [c*BANK_W +: BANK_W]
- ch_index  in  NUM_CH*IDX_W  per-channel colour index, same packing
- ch_flash  in  NUM_CH  per-channel flash participation
- pix_valid_out  out  1  output pixel valid
- red, green, blue  out  4 each  composited colour
- hit  out  1  a sprite channel supplied the pixel
- hit_ch  out  max(1,$clog2(NUM_CH))  winning channel number
- flash_phase  out  1  current flash phase

Function
REQ-007 The palette SHALL be a register array of 2^BANK_W * 2^IDX_W entries of 12 bits each.
REQ-008 When wr_en=1 at a rising edge, the block SHALL write wr_rgb to entry [wr_bank][wr_index] at that edge.
REQ-009 The effective bank of channel c SHALL be ch_bank[c] XOR 1 when flash_en=1, ch_flash[c]=1 and flash_phase=1; otherwise it SHALL be ch_bank[c].
REQ-010 Stage 1: on each edge, the block SHALL register pix_valid_in, and for every channel it SHALL register the palette read of [effective bank][ch_index], a transparent flag (ch_index==TRANS_IDX) and ch_active.
REQ-011 A read in the same cycle as a write to the same entry SHALL return the old (pre-write) value.
REQ-012 Stage 2: on each edge, the block SHALL register the composite. The winner is the lowest-numbered channel with active=1 and transparent=0. On a winner, the outputs SHALL be its colour, hit=1 and hit_ch=its number; with no winner, the outputs SHALL be bg_rgb (sampled at stage 2), hit=0 and hit_ch=0.
REQ-013 Latency SHALL be exactly 2 cycles: the request sampled at edge N appears on the outputs after edge N+1, with pix_valid_out=1.
REQ-014 The pipeline SHALL accept a new request every cycle; there is no backpressure.
REQ-015 When pix_valid_in=0, stage data SHALL still advance, but pix_valid_out SHALL be 0 for that slot.
REQ-016 A frame counter SHALL increment on each frame_start pulse. On reaching FLASH_FRAMES-1 while frame_start=1, the counter SHALL wrap to 0 and flash_phase SHALL toggle.
REQ-017 The frame counter SHALL run only while flash_en=1. A 1->0 transition of flash_en SHALL clear the counter and flash_phase on the next edge.
REQ-018 A flash_phase change SHALL affect stage-1 lookups from the edge after the toggle; pixels already in flight SHALL be unaffected.
REQ-019 Bank XOR 1 SHALL wrap within range; with BANK_W=1, banks 0 and 1 swap.
REQ-020 Writes SHALL be independent of pixel requests; writes and reads in the same cycle are legal.

Reset
REQ-021 While Reset_n=0, the block SHALL asynchronously set all palette entries to 12'h000.
REQ-022 While Reset_n=0, the block SHALL asynchronously clear all pipeline registers, the frame counter and flash_phase.
REQ-023 While Reset_n=0, the block SHALL hold pix_valid_out, red, green, blue, hit and hit_ch at 0.
REQ-024 Reset mid-stream SHALL discard in-flight pixels; the first valid output after release SHALL come 2 edges after the first sampled request.

Verification
REQ-025 The bench SHALL cover write then lookup: write bank1 idx5=12'hEA0; ch0 active, bank1, idx5 -> 2 cycles later rgb=E,A,0, hit=1, hit_ch=0.
REQ-026 The bench SHALL cover priority/transparency: ch0 idx=TRANS_IDX, ch1 idx3 (=12'h560), ch2 idx4 (=12'hFA0) -> rgb=5,6,0, hit_ch=1; with all channels transparent -> bg_rgb, hit=0.
REQ-027 The bench SHALL cover read-during-write: entry [0][2] old=12'h777, write 12'hD07 while reading [0][2] -> output 7,7,7; the next read returns D,0,7.
REQ-028 The bench SHALL cover flash: FLASH_FRAMES=2, flash_en=1, ch0 ch_flash=1 bank0 -> after 2 frame_start pulses flash_phase=1 and the lookup uses bank1; dropping flash_en -> flash_phase=0 next edge.
REQ-029 The bench SHALL cover throughput: back-to-back requests with pix_valid_in pattern 1,0,1,1 -> pix_valid_out pattern 1,0,1,1 delayed 2 cycles, with matching colours.
REQ-030 The bench SHALL cover mid-stream reset: assert Reset_n=0 with 2 pixels in flight -> outputs 0 immediately; after release, the palette reads 12'h000 and no stale pix_valid_out appears.
